// File: rtl/ssp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ssp_pkg
//  Description : Shared SSP definitions used by the transmit/receive shifters
//                and the FIFOs: frame width and the shifter state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package ssp_pkg;

    // Bits per serial frame, also the FIFO word width.
    localparam int SSP_DATA_WIDTH = 8;

    // Receive shifter states. The explicit one-bit base keeps the state
    // register exactly one flop wide.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_t;

endpackage : ssp_pkg
`default_nettype wire

// File: rtl/ssp_edge_det.sv
`default_nettype none
// ============================================================================
//  Module      : ssp_edge_det
//  Description : Single-flop edge detector for a signal that is already
//                synchronous to clk (e.g. SSPCLKIN generated in the PCLK
//                domain). Produces one-cycle rise/fall pulses.
//  Ports       : clk      system clock
//                rst      synchronous active-high reset (clears history to 0)
//                i_sig    signal to watch
//                o_rise   i_sig is 1 now and was 0 last cycle
//                o_fall   i_sig is 0 now and was 1 last cycle
//  Revision    : 1.0  initial release
// ============================================================================
module ssp_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_rise,
    output logic o_fall
);

    logic sig_q;
    logic sig_d;

    always_comb begin
        sig_d = i_sig;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_d;
        end
    end

    // History resets to 0, so an input already high when reset releases
    // is seen as a rise on the first cycle.
    assign o_rise = i_sig & ~sig_q;
    assign o_fall = ~i_sig & sig_q;

endmodule : ssp_edge_det
`default_nettype wire

// File: rtl/ssp_rx_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : ssp_rx_shifter
//  Description : SSP serial receive front end. Samples SSPRXD on SSPCLKIN
//                rises, frames with SSPFSSIN, assembles MSB-first words and
//                hands them to the receive FIFO through a one-word holding
//                register. Flags a sticky overrun when a word is lost.
//  Ports       : PCLK        system clock
//                CLEAR       synchronous active-high reset
//                SSPCLKIN    serial clock (PCLK domain, half rate)
//                SSPFSSIN    frame sync, high at the rise before the MSB
//                SSPRXD      serial data
//                RX_FULL     receive FIFO full
//                RX_DATA     holding register contents
//                RX_WR       FIFO write strobe (word pending and not full)
//                RX_BUSY     frame in progress
//                RX_OVERRUN  sticky word-lost flag
//  Revision    : 1.0  initial release
// ============================================================================
module ssp_rx_shifter
    import ssp_pkg::*;
#(
    parameter int DATA_WIDTH = SSP_DATA_WIDTH,
    // Must satisfy 2**CNT_W > DATA_WIDTH.
    parameter int CNT_W      = 4
) (
    input  logic                  PCLK,
    input  logic                  CLEAR,
    input  logic                  SSPCLKIN,
    input  logic                  SSPFSSIN,
    input  logic                  SSPRXD,
    input  logic                  RX_FULL,
    output logic [DATA_WIDTH-1:0] RX_DATA,
    output logic                  RX_WR,
    output logic                  RX_BUSY,
    output logic                  RX_OVERRUN
);

    localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    rx_state_t             state_q,   state_d;
    logic [CNT_W-1:0]      cnt_q,     cnt_d;
    // Only the first DATA_WIDTH-1 bits are ever held here; the final bit
    // goes straight from SSPRXD into the holding register.
    logic [DATA_WIDTH-2:0] shreg_q,   shreg_d;
    logic [DATA_WIDTH-1:0] hold_q,    hold_d;
    logic                  pend_q,    pend_d;
    logic                  overrun_q, overrun_d;

    logic w_rise;
    logic w_unused_fall;
    logic w_rx_wr;
    logic w_complete;

    ssp_edge_det u_edge_det (
        .clk    (PCLK),
        .rst    (CLEAR),
        .i_sig  (SSPCLKIN),
        .o_rise (w_rise),
        .o_fall (w_unused_fall)
    );

    assign w_rx_wr = pend_q & ~RX_FULL;

    // ------------------------------------------------------------------
    // Framing FSM, bit counter and shift register
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        w_complete = 1'b0;

        if (w_rise) begin
            case (state_q)
                IDLE: begin
                    if (SSPFSSIN) begin
                        state_d = SHIFT;
                        cnt_d   = '0;
                    end
                end
                SHIFT: begin
                    shreg_d = {shreg_q[DATA_WIDTH-3:0], SSPRXD};
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == C_LAST_BIT) begin
                        w_complete = 1'b1;
                        cnt_d      = '0;
                        // Frame sync on the final bit chains straight into
                        // the next frame with no idle gap.
                        state_d    = SSPFSSIN ? SHIFT : IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Holding register / FIFO handoff
    // ------------------------------------------------------------------
    always_comb begin
        hold_d    = hold_q;
        pend_d    = pend_q;
        overrun_d = overrun_q;

        if (w_rx_wr) begin
            pend_d = 1'b0;
        end

        if (w_complete) begin
            // A write this cycle frees the slot, so the new word can take
            // it in the same edge (drain and fill together).
            if (!pend_q || w_rx_wr) begin
                hold_d = {shreg_q, SSPRXD};
                pend_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (CLEAR) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            hold_q    <= '0;
            pend_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            hold_q    <= hold_d;
            pend_q    <= pend_d;
            overrun_q <= overrun_d;
        end
    end

    assign RX_DATA    = hold_q;
    assign RX_WR      = w_rx_wr;
    assign RX_BUSY    = (state_q == SHIFT);
    assign RX_OVERRUN = overrun_q;

endmodule : ssp_rx_shifter
`default_nettype wire

// File: tb/tb_ssp_rx_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ssp_rx_shifter
//  Description : Self-checking bench for ssp_rx_shifter. A word-level model
//                (bit queue per frame, one-slot hold) predicts the outputs
//                every PCLK; directed scenarios also check write timing.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ssp_rx_shifter;

    localparam int DW = 8;

    logic          PCLK;
    logic          CLEAR;
    logic          SSPCLKIN;
    logic          SSPFSSIN;
    logic          SSPRXD;
    logic          RX_FULL;
    logic [DW-1:0] RX_DATA;
    logic          RX_WR;
    logic          RX_BUSY;
    logic          RX_OVERRUN;

    ssp_rx_shifter dut (
        .PCLK       (PCLK),
        .CLEAR      (CLEAR),
        .SSPCLKIN   (SSPCLKIN),
        .SSPFSSIN   (SSPFSSIN),
        .SSPRXD     (SSPRXD),
        .RX_FULL    (RX_FULL),
        .RX_DATA    (RX_DATA),
        .RX_WR      (RX_WR),
        .RX_BUSY    (RX_BUSY),
        .RX_OVERRUN (RX_OVERRUN)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // stimulus controls
    logic g_clr       = 1'b0;
    logic g_check     = 1'b0;
    logic g_rand_full = 1'b0;
    int   g_full_until = 0;

    // reference model state
    logic          m_prev    = 1'b0;
    logic          m_busy    = 1'b0;
    logic          m_pend    = 1'b0;
    logic [DW-1:0] m_hold    = '0;
    logic          m_overrun = 1'b0;
    logic          m_bits[$];
    int            m_wr_cnt  = 0;
    int            obs_wr_cnt = 0;

    // observed write log
    int            wcyc[$];
    logic [DW-1:0] wdat[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    // One PCLK cycle: drive inputs, check outputs against the model, then
    // advance the model to what the coming edge should produce.
    task automatic tick(input logic sclk, input logic fss, input logic rxd);
        logic          full;
        logic          exp_wr;
        logic          rise;
        logic          done;
        int            word;
        @(negedge PCLK);
        full     = g_rand_full ? ($urandom_range(0, 3) == 0) : (cyc < g_full_until);
        SSPCLKIN = sclk;
        SSPFSSIN = fss;
        SSPRXD   = rxd;
        RX_FULL  = full;
        CLEAR    = g_clr;
        #1;
        exp_wr = m_pend & ~full;
        if (g_check) begin
            chk("rx_wr",   {31'd0, RX_WR},      {31'd0, exp_wr});
            chk("rx_data", {24'd0, RX_DATA},    {24'd0, m_hold});
            chk("rx_busy", {31'd0, RX_BUSY},    {31'd0, m_busy});
            chk("overrun", {31'd0, RX_OVERRUN}, {31'd0, m_overrun});
        end
        if (RX_WR === 1'b1) begin
            wcyc.push_back(cyc);
            wdat.push_back(RX_DATA);
            obs_wr_cnt++;
        end
        if (exp_wr) m_wr_cnt++;

        if (g_clr) begin
            m_prev = 1'b0; m_busy = 1'b0; m_pend = 1'b0;
            m_hold = '0;   m_overrun = 1'b0;
            m_bits.delete();
        end else begin
            rise = sclk & ~m_prev;
            done = 1'b0;
            word = 0;
            if (rise) begin
                if (!m_busy) begin
                    if (fss) begin
                        m_busy = 1'b1;
                        m_bits.delete();
                    end
                end else begin
                    m_bits.push_back(rxd);
                    if (m_bits.size() == DW) begin
                        foreach (m_bits[i]) word = word * 2 + int'(m_bits[i]);
                        m_bits.delete();
                        done   = 1'b1;
                        m_busy = fss;
                    end
                end
            end
            if (done) begin
                if (!m_pend || exp_wr) begin
                    m_hold = DW'(word);
                    m_pend = 1'b1;
                end else begin
                    m_overrun = 1'b1;
                end
            end else if (exp_wr) begin
                m_pend = 1'b0;
            end
            m_prev = sclk;
        end
        @(posedge PCLK);
        #1;
        cyc++;
    endtask

    task automatic period(input logic fss, input logic rxd);
        tick(1'b0, fss, rxd);
        tick(1'b1, fss, rxd);
    endtask

    task automatic send_byte(input logic [DW-1:0] b, input logic fss_last, input logic noise);
        for (int i = DW - 1; i >= 0; i--) begin
            period((i == 0) ? fss_last : (noise ? 1'($urandom_range(0, 1)) : 1'b0), b[i]);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) period(1'b0, 1'($urandom_range(0, 1)));
    endtask

    task automatic clear_log();
        wcyc.delete();
        wdat.delete();
    endtask

    int c_last;

    initial begin
        CLEAR = 1'b1; SSPCLKIN = 1'b0; SSPFSSIN = 1'b0; SSPRXD = 1'b0; RX_FULL = 1'b0;

        // ---- power-on reset ----
        g_clr = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        g_clr = 1'b0;
        g_check = 1'b1;
        chk("rst_data", {24'd0, RX_DATA}, 32'h0);
        chk("rst_wr",   {31'd0, RX_WR},   32'h0);

        // ---- single frame 0xA5 ----
        idle(2);
        clear_log();
        period(1'b1, 1'b0);
        send_byte(8'hA5, 1'b0, 1'b0);
        c_last = cyc - 1;
        idle(3);
        chk("single_nwr",  wcyc.size(), 1);
        if (wcyc.size() >= 1) begin
            chk("single_data", {24'd0, wdat[0]}, 32'hA5);
            chk("single_lat",  wcyc[0], c_last + 1);
        end
        chk("single_busy", {31'd0, RX_BUSY}, 32'h0);

        // ---- back-to-back 0x3C, 0xC3 ----
        clear_log();
        period(1'b1, 1'b1);
        send_byte(8'h3C, 1'b1, 1'b0);
        chk("b2b_busy", {31'd0, RX_BUSY}, 32'h1);
        send_byte(8'hC3, 1'b0, 1'b0);
        idle(3);
        chk("b2b_nwr", wcyc.size(), 2);
        if (wcyc.size() == 2) begin
            chk("b2b_d0",  {24'd0, wdat[0]}, 32'h3C);
            chk("b2b_d1",  {24'd0, wdat[1]}, 32'hC3);
            chk("b2b_gap", wcyc[1] - wcyc[0], 16);
        end

        // ---- backpressure: 0x81 completes while full, release 5 later ----
        clear_log();
        g_full_until = 32'h7fff_ffff;
        period(1'b1, 1'b0);
        send_byte(8'h81, 1'b0, 1'b0);
        c_last = cyc - 1;
        g_full_until = c_last + 5;
        idle(5);
        chk("bp_nwr", wcyc.size(), 1);
        if (wcyc.size() >= 1) begin
            chk("bp_data", {24'd0, wdat[0]}, 32'h81);
            chk("bp_cyc",  wcyc[0], c_last + 5);
        end
        chk("bp_ovr", {31'd0, RX_OVERRUN}, 32'h0);

        // ---- overrun: 0x11 and 0x22 both complete while full ----
        clear_log();
        g_full_until = 32'h7fff_ffff;
        period(1'b1, 1'b0);
        send_byte(8'h11, 1'b0, 1'b0);
        period(1'b1, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        chk("ovr_set", {31'd0, RX_OVERRUN}, 32'h1);
        g_full_until = cyc;
        idle(3);
        chk("ovr_nwr", wcyc.size(), 1);
        if (wcyc.size() >= 1) chk("ovr_data", {24'd0, wdat[0]}, 32'h11);
        chk("ovr_sticky", {31'd0, RX_OVERRUN}, 32'h1);

        // ---- mid-stream CLEAR for 3 PCLK ----
        period(1'b1, 1'b1);
        period(1'b0, 1'b1);
        g_clr = 1'b1;
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        g_clr = 1'b0;
        chk("clr_data", {24'd0, RX_DATA},    32'h0);
        chk("clr_wr",   {31'd0, RX_WR},      32'h0);
        chk("clr_busy", {31'd0, RX_BUSY},    32'h0);
        chk("clr_ovr",  {31'd0, RX_OVERRUN}, 32'h0);

        // ---- abort: 4 bits of 0xF0, CLEAR, then 0x5A ----
        clear_log();
        period(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) period(1'b0, 1'b1);
        g_clr = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        g_clr = 1'b0;
        idle(2);
        chk("abort_nowr", wcyc.size(), 0);
        period(1'b1, 1'b0);
        send_byte(8'h5A, 1'b0, 1'b0);
        idle(3);
        chk("abort_nwr", wcyc.size(), 1);
        if (wcyc.size() >= 1) chk("abort_data", {24'd0, wdat[0]}, 32'h5A);

        // ---- randomized frames with random backpressure ----
        g_rand_full = 1'b1;
        for (int f = 0; f < 24; f++) begin
            int nb;
            idle($urandom_range(0, 2));
            period(1'b1, 1'($urandom_range(0, 1)));
            nb = $urandom_range(1, 3);
            for (int k = 0; k < nb; k++) begin
                send_byte(8'($urandom), (k != nb - 1), 1'b1);
            end
        end
        g_rand_full = 1'b0;
        g_full_until = 0;
        idle(4);
        chk("rand_wr_count", obs_wr_cnt, m_wr_cnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ssp_rx_shifter
`default_nettype wire
